// File: rtl/parking_exit_controller_if.sv
// Signal bundle between the exit-booth hardware and the parking exit controller.
// The master side drives sensors, entry pulses and code digits; the slave side is the controller.
interface parking_exit_controller_if;
    logic       sensor_exit_inner;
    logic       sensor_exit_outer;
    logic       car_entered;
    logic [1:0] exit_code_1;
    logic [1:0] exit_code_2;
    logic       GATE_OPEN;
    logic       GREEN_LED;
    logic       RED_LED;
    logic       FULL;
    logic [3:0] occupancy;
    logic [6:0] HEX_1;
    logic [6:0] HEX_2;

    modport master (
        output sensor_exit_inner, sensor_exit_outer, car_entered, exit_code_1, exit_code_2,
        input  GATE_OPEN, GREEN_LED, RED_LED, FULL, occupancy, HEX_1, HEX_2
    );

    modport slave (
        input  sensor_exit_inner, sensor_exit_outer, car_entered, exit_code_1, exit_code_2,
        output GATE_OPEN, GREEN_LED, RED_LED, FULL, occupancy, HEX_1, HEX_2
    );
endinterface

// File: rtl/parking_exit_controller.sv
// Exit-gate controller: Moore FSM that validates an exit code, opens the barrier,
// detects tailgating and keeps a saturating count of cars inside.
module parking_exit_controller #(
    parameter int CAPACITY     = 15,
    parameter int WAIT_CYCLES  = 4,
    parameter int OPEN_TIMEOUT = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    parking_exit_controller_if.slave bus
);
    localparam int MAX_CNT = (WAIT_CYCLES > OPEN_TIMEOUT) ? WAIT_CYCLES : OPEN_TIMEOUT;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] OPEN_LAST = CNT_W'(OPEN_TIMEOUT - 1);
    localparam logic [3:0]       CAP       = 4'(CAPACITY);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_WRONG = 3'd2,
        S_OPEN  = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       occ_q, occ_d;
    logic             blink_q, blink_d;
    logic             code_ok_s, dec_s;
    logic             gate_s, green_s, red_s;
    logic [6:0]       hex1_s, hex2_s;

    assign code_ok_s = (bus.exit_code_1 == 2'b10) && (bus.exit_code_2 == 2'b01);

    // State, counter, occupancy and blink registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            occ_q   <= 4'd0;
            blink_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            occ_q   <= occ_d;
            blink_q <= blink_d;
        end
    end

    // Next-state logic plus counter, blink and occupancy updates
    always_comb begin
        state_d = state_q;
        dec_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.sensor_exit_inner && (occ_q != 4'd0)) state_d = S_CHECK;
                else                                          state_d = S_IDLE;
            end
            S_CHECK: begin
                if (!bus.sensor_exit_inner) state_d = S_IDLE;
                else if (cnt_q == WAIT_LAST) state_d = code_ok_s ? S_OPEN : S_WRONG;
                else                         state_d = S_CHECK;
            end
            S_WRONG: begin
                if (code_ok_s)                   state_d = S_OPEN;
                else if (!bus.sensor_exit_inner) state_d = S_IDLE;
                else                             state_d = S_WRONG;
            end
            S_OPEN: begin
                if (bus.sensor_exit_inner && bus.sensor_exit_outer) begin
                    state_d = S_STOP;
                end else if (bus.sensor_exit_outer) begin
                    state_d = S_IDLE;
                    dec_s   = 1'b1;
                end else if (cnt_q == OPEN_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_OPEN;
                end
            end
            S_STOP: begin
                if (code_ok_s) state_d = S_OPEN;
                else           state_d = S_STOP;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q)                          cnt_d = '0;
        else if (state_q == S_CHECK || state_q == S_OPEN) cnt_d = cnt_q + CNT_W'(1);
        else                                             cnt_d = cnt_q;

        if (state_q == S_WRONG || state_q == S_STOP) blink_d = ~blink_q;
        else                                         blink_d = 1'b0;

        // An entry and an exit on the same edge cancel out, even at the limits
        if (bus.car_entered && dec_s)  occ_d = occ_q;
        else if (bus.car_entered)      occ_d = (occ_q == CAP) ? occ_q : occ_q + 4'd1;
        else if (dec_s)                occ_d = (occ_q == 4'd0) ? occ_q : occ_q - 4'd1;
        else                           occ_d = occ_q;
    end

    // Moore output decode from the current state
    always_comb begin
        gate_s  = 1'b0;
        green_s = 1'b0;
        red_s   = 1'b0;
        hex1_s  = 7'b1111111;
        hex2_s  = 7'b1111111;
        case (state_q)
            S_IDLE: begin
                hex1_s = 7'b1111111;
                hex2_s = 7'b1111111;
            end
            S_CHECK: begin
                red_s  = 1'b1;
                hex1_s = 7'b0000110;
                hex2_s = 7'b0001001;
            end
            S_WRONG: begin
                red_s  = blink_q;
                hex1_s = 7'b0000110;
                hex2_s = 7'b0000110;
            end
            S_OPEN: begin
                gate_s  = 1'b1;
                green_s = 1'b1;
                hex1_s  = 7'b0000010;
                hex2_s  = 7'b1000000;
            end
            S_STOP: begin
                red_s  = blink_q;
                hex1_s = 7'b0010010;
                hex2_s = 7'b0001100;
            end
            default: begin
                hex1_s = 7'b1111111;
                hex2_s = 7'b1111111;
            end
        endcase
    end

    assign bus.GATE_OPEN = gate_s;
    assign bus.GREEN_LED = green_s;
    assign bus.RED_LED   = red_s;
    assign bus.HEX_1     = hex1_s;
    assign bus.HEX_2     = hex2_s;
    assign bus.occupancy = occ_q;
    assign bus.FULL      = (occ_q == CAP);
endmodule

// File: doc/parking_exit_controller.md
PARKING_EXIT_CONTROLLER -- requirements
Module: parking_exit_controller

Interface
REQ-001 Parameter CAPACITY, default 15, maximum occupancy count (1..15).
REQ-002 Parameter WAIT_CYCLES, default 4, cycles spent in CHECK before the exit code is sampled (>=1).
REQ-003 Parameter OPEN_TIMEOUT, default 32, cycles OPEN may last without an outer-sensor event (>=1).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  reset, asynchronous and active-high.
REQ-006 sensor_exit_inner  input  1  car present at exit booth.
REQ-007 sensor_exit_outer  input  1  car has passed the exit gate.
REQ-008 car_entered  input  1  one-cycle pulse from the entrance controller, one car admitted.
REQ-009 exit_code_1  input  2  first exit-code digit.
REQ-010 exit_code_2  input  2  second exit-code digit.
REQ-011 GATE_OPEN  output  1  exit barrier open.
REQ-012 GREEN_LED  output  1  green lamp.
REQ-013 RED_LED  output  1  red lamp.
REQ-014 FULL  output  1  occupancy equals CAPACITY.
REQ-015 occupancy  output  4  cars currently inside.
REQ-016 HEX_1  output  7  left seven-segment digit, active-low, segment order gfedcba.
REQ-017 HEX_2  output  7  right seven-segment digit, same encoding as HEX_1.

Function
REQ-018 The exit code SHALL be valid iff exit_code_1==2'b10 and exit_code_2==2'b01.
REQ-019 The Moore FSM SHALL have states IDLE, CHECK, WRONG, OPEN and STOP; GATE_OPEN, GREEN_LED, HEX_1 and HEX_2 SHALL depend only on the current state.
REQ-020 IDLE: sensor_exit_inner==1 and occupancy!=0 -> CHECK; otherwise stay in IDLE.
REQ-021 CHECK: the block SHALL remain in CHECK for exactly WAIT_CYCLES cycles, then go to OPEN if the code is valid in the last CHECK cycle, else to WRONG.
REQ-022 CHECK: if sensor_exit_inner drops before WAIT_CYCLES elapse -> IDLE.
REQ-023 WRONG: valid code -> OPEN; else sensor_exit_inner==0 -> IDLE; else stay in WRONG.
REQ-024 OPEN: sensor_exit_inner==1 and sensor_exit_outer==1 in the same cycle (tailgate) -> STOP, with no decrement.
REQ-025 OPEN: sensor_exit_outer==1 alone -> IDLE, with occupancy decremented on that edge.
REQ-026 OPEN: OPEN_TIMEOUT cycles without sensor_exit_outer -> IDLE, with no decrement.
REQ-027 STOP: valid code -> OPEN; otherwise stay in STOP.
REQ-028 A single cycle counter SHALL clear on every state change and increment each cycle in CHECK and OPEN; its width SHALL cover max(WAIT_CYCLES, OPEN_TIMEOUT).
REQ-029 car_entered SHALL increment occupancy, saturating at CAPACITY.
REQ-030 Occupancy decrement SHALL saturate at 0.
REQ-031 A simultaneous increment and decrement SHALL leave occupancy unchanged.
REQ-032 FULL SHALL be combinational (occupancy==CAPACITY).
REQ-033 Output decode by state:
  - IDLE: GATE_OPEN 0, GREEN 0, RED 0, HEX 7'b1111111 / 7'b1111111.
  - CHECK: GATE_OPEN 0, GREEN 0, RED 1, HEX E 7'b0000110 / H 7'b0001001.
  - WRONG: GATE_OPEN 0, GREEN 0, RED blinking, HEX E / E.
  - OPEN: GATE_OPEN 1, GREEN 1, RED 0, HEX 6 7'b0000010 / 0 7'b1000000.
  - STOP: GATE_OPEN 0, GREEN 0, RED blinking, HEX 5 7'b0010010 / P 7'b0001100.
REQ-034 Blinking RED SHALL be a register that toggles every cycle while in WRONG or STOP and is 0 in all other states.
REQ-035 An unreachable state encoding SHALL return to IDLE on the next edge.

Reset
REQ-036 While reset==1, the FSM SHALL be held in IDLE, immediately and without waiting for a clock edge.
REQ-037 While reset==1, the cycle counter, occupancy and the blink register SHALL be held at 0.
REQ-038 While reset==1, outputs SHALL read GATE_OPEN=0, GREEN=0, RED=0, FULL=0, HEX_1=HEX_2=7'b1111111.
REQ-039 Reset asserted mid-operation, including in OPEN, SHALL discard any pending decrement.

Verification
REQ-040 Reset then 3 car_entered pulses -> occupancy=3, FULL=0.
  Inner=1 with code 10/01 held -> CHECK for 4 cycles, then OPEN (GATE_OPEN=1, HEX 6/0).
  Outer pulse -> IDLE, occupancy=2.
REQ-041 Occupancy=1, inner=1, code 01/10 -> WRONG after 4 cycles, RED toggling each cycle, HEX E/E.
  Code changed to 10/01 -> OPEN on the next edge.
REQ-042 In OPEN, inner=1 and outer=1 together -> STOP, HEX 5/P, occupancy unchanged.
  Valid code -> OPEN.
REQ-043 In OPEN, no outer for 32 cycles -> IDLE, occupancy unchanged.
  Occupancy=0 with inner=1 -> stays IDLE.
REQ-044 15 car_entered pulses -> occupancy=15, FULL=1.
  16th pulse -> occupancy stays 15.
  car_entered in the same cycle as an OPEN-state outer event -> occupancy unchanged.
REQ-045 Reset pulse asserted between clock edges while in OPEN -> GATE_OPEN=0 and occupancy=0 before the next edge.
